bomb_field_gen: RTL and testbench

- Generates a minesweeper bomb field: places exactly `num_bombs` distinct bombs on a GRID_W x GRID_H board.
- Draws candidate cells from an internal LFSR and rejects duplicates and out-of-range indices, so placement is always unique.
- Sits between the game controller, which issues start/seed, and the board/VGA logic, which reads `bomb_map`.
- Generalised successor of the fixed 64-entry random list: board size, bomb limit and LFSR width are all parameters, and it has a start/done handshake.

---
 rtl/bomb_field_pkg.sv | 41 ++++
 rtl/lfsr_fib.sv | 30 +++
 rtl/bomb_field_gen.sv | 129 ++++++++++++
 tb/tb_bomb_field_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_field_pkg.sv
// rtl/bomb_field_pkg.sv - shared state type, default seed and LFSR tap table for bomb_field_gen
package bomb_field_pkg;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  // XOR feedback masks, bit w-1 is the oldest stage; every entry is maximal-length
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    case (w)
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      default: t = 32'h8020_0003;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_fib.sv
// rtl/lfsr_fib.sv - Fibonacci LFSR with seed load; an all-zero seed is replaced by the default seed
module lfsr_fib
  import bomb_field_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed_in,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [31:0]  TAPS32  = lfsr_taps(W);
  localparam logic [31:0]  DSEED32 = {16'h0000, DEFAULT_SEED};
  localparam logic [W-1:0] TAPS    = TAPS32[W-1:0];
  localparam logic [W-1:0] DSEED   = DSEED32[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= DSEED;
    end else if (load) begin
      q <= (seed_in == '0) ? DSEED : seed_in;
    end else if (en) begin
      q <= {q[W-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/bomb_field_gen.sv
// rtl/bomb_field_gen.sv - places num_bombs distinct bombs on a GRID_W x GRID_H board from an LFSR
// Optional macro SAFE_CELL_EN adds a safe_idx cell that never receives a bomb.
module bomb_field_gen
  import bomb_field_pkg::*;
#(
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 8,
  parameter int MAX_BOMBS = 63,
  parameter int LFSR_W    = 16,
  localparam int CELLS    = GRID_W * GRID_H,
  localparam int IDX_W    = $clog2(CELLS),
  localparam int CNT_W    = $clog2(MAX_BOMBS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_bombs,
  input  logic [LFSR_W-1:0] seed,
`ifdef SAFE_CELL_EN
  input  logic [IDX_W-1:0]  safe_idx,
`endif
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_bomb,
  output logic [CELLS-1:0]  bomb_map,
  output logic [CNT_W-1:0]  bomb_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int EXT   = 2 ** IDX_W;
  localparam int LIMIT = (MAX_BOMBS < CELLS - 1) ? MAX_BOMBS : CELLS - 1;
  localparam logic [IDX_W:0]   CELLS_L = CELLS[IDX_W:0];
  localparam logic [CNT_W-1:0] LIMIT_L = LIMIT[CNT_W-1:0];

  state_t            state;
  logic [CNT_W-1:0]  target;
  logic [LFSR_W-1:0] lfsr_q;
  logic [IDX_W-1:0]  cand;
  logic [EXT-1:0]    map_ext;
  logic              cand_ok, req_bad, accept, safe_bad, is_safe;

`ifdef SAFE_CELL_EN
  logic [IDX_W-1:0] safe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      safe_q <= '0;
    end else if (accept) begin
      safe_q <= safe_idx;
    end
  end

  assign safe_bad = ({1'b0, safe_idx} >= CELLS_L);
  assign is_safe  = (cand == safe_q);
`else
  assign safe_bad = 1'b0;
  assign is_safe  = 1'b0;
`endif

  // Pad the map to a power of two so any IDX_W index reads a defined 0 past CELLS
  always_comb begin
    map_ext = '0;
    map_ext[CELLS-1:0] = bomb_map;
  end

  assign cand    = lfsr_q[IDX_W-1:0];
  assign req_bad = (num_bombs > LIMIT_L) || safe_bad;
  assign accept  = (state == IDLE) && start && !req_bad;
  assign cand_ok = ({1'b0, cand} < CELLS_L) && !map_ext[cand] && !is_safe;
  assign rd_bomb = ({1'b0, rd_idx} < CELLS_L) && map_ext[rd_idx];

  if (LFSR_W > IDX_W) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:IDX_W];
  end

  lfsr_fib #(.W(LFSR_W)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .seed_in (seed),
    .en      (state == FILL),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      bomb_map   <= '0;
      bomb_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              target     <= num_bombs;
              bomb_map   <= '0;
              bomb_count <= '0;
              busy       <= 1'b1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (bomb_count == target) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cand_ok) begin
            bomb_map[cand] <= 1'b1;
            bomb_count     <= bomb_count + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_field_gen.sv
// tb/tb_bomb_field_gen.sv - scoreboard bench for bomb_field_gen on 8x8 and 5x5 boards
module tb_bomb_field_gen;

  typedef struct {
    bit          is_err;
    logic [63:0] map;
    int          count;
    int          lat;
    int          due;
  } exp_t;

`ifdef SAFE_CELL_EN
  localparam int SAFE8 = 27;
  localparam int SAFE5 = 3;
`else
  localparam int SAFE8 = -1;
  localparam int SAFE5 = -1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        start8, rdb8, busy8, done8, err8;
  logic [5:0]  num8, cnt8, rd8;
  logic [5:0]  safe8 = 6'd27;
  logic [15:0] seed8;
  logic [63:0] map8;
  logic        start5, rdb5, busy5, done5, err5;
  logic [4:0]  num5, cnt5, rd5;
  logic [4:0]  safe5 = 5'd3;
  logic [15:0] seed5;
  logic [24:0] map5;

  bomb_field_gen #(.GRID_W(8), .GRID_H(8), .MAX_BOMBS(63), .LFSR_W(16)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .num_bombs(num8), .seed(seed8),
`ifdef SAFE_CELL_EN
    .safe_idx(safe8),
`endif
    .rd_idx(rd8), .rd_bomb(rdb8), .bomb_map(map8), .bomb_count(cnt8),
    .busy(busy8), .done(done8), .err(err8)
  );

  bomb_field_gen #(.GRID_W(5), .GRID_H(5), .MAX_BOMBS(24), .LFSR_W(16)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .num_bombs(num5), .seed(seed5),
`ifdef SAFE_CELL_EN
    .safe_idx(safe5),
`endif
    .rd_idx(rd5), .rd_bomb(rdb5), .bomb_map(map5), .bomb_count(cnt5),
    .busy(busy5), .done(done5), .err(err5)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        q8[$];
  exp_t        q5[$];
  exp_t        m8, m5;
  logic [63:0] last_map [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: walk the 16-bit maximal sequence, keep unseen in-range cells until n are placed
  function automatic exp_t model(input int cells, input int idxw, input int safe,
                                 input logic [15:0] sd, input int n);
    exp_t e;
    logic [15:0] s;
    int c, placed, p;
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    e.is_err = 1'b0;
    e.map = '0;
    e.count = n;
    e.due = 0;
    placed = 0;
    p = 0;
    while (placed < n && p < 200000) begin
      c = int'(s) % (1 << idxw);
      if (c < cells && c != safe && e.map[c] == 1'b0) begin
        e.map[c] = 1'b1;
        placed++;
      end
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
      p++;
    end
    e.lat = p + 2;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && (done8 || err8)) begin
      if (q8.size() == 0) begin
        chk("d8_unexpected_pulse", {62'd0, done8, err8}, 64'd0);
      end else begin
        m8 = q8.pop_front();
        chk("d8_err", {63'd0, err8}, {63'd0, m8.is_err});
        chk("d8_done", {63'd0, done8}, {63'd0, !m8.is_err});
        chk("d8_map", map8, m8.map);
        chk("d8_count", {58'd0, cnt8}, 64'(m8.count));
        chk("d8_time", 64'(cyc), 64'(m8.due));
        chk("d8_busy_at_pulse", {63'd0, busy8}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (done5 || err5)) begin
      if (q5.size() == 0) begin
        chk("d5_unexpected_pulse", {62'd0, done5, err5}, 64'd0);
      end else begin
        m5 = q5.pop_front();
        chk("d5_err", {63'd0, err5}, {63'd0, m5.is_err});
        chk("d5_done", {63'd0, done5}, {63'd0, !m5.is_err});
        chk("d5_map", {39'd0, map5}, m5.map);
        chk("d5_count", {59'd0, cnt5}, 64'(m5.count));
        chk("d5_time", 64'(cyc), 64'(m5.due));
        chk("d5_busy_at_pulse", {63'd0, busy5}, 64'd0);
      end
    end
  end

  task automatic req(input int d, input logic [15:0] sd, input int n, input bit poke);
    exp_t e;
    int pend;
    int ix;
    if (n > (d ? 24 : 63)) begin
      e.is_err = 1'b1;
      e.map = last_map[d];
      e.count = $countones(last_map[d]);
      e.lat = 1;
    end else begin
      e = model(d ? 25 : 64, d ? 5 : 6, d ? SAFE5 : SAFE8, sd, n);
      last_map[d] = e.map;
    end
    e.due = cyc + e.lat;
    if (d != 0) begin
      q5.push_back(e);
      start5 = 1'b1; seed5 = sd; num5 = 5'(n);
    end else begin
      q8.push_back(e);
      start8 = 1'b1; seed8 = sd; num8 = 6'(n);
    end
    @(negedge clk);
    start5 = 1'b0;
    start8 = 1'b0;
    chk($sformatf("d%0d_busy_after_start", d ? 5 : 8), {63'd0, d ? busy5 : busy8},
        {63'd0, !e.is_err});
    if (poke) begin
      @(negedge clk);
      if (d != 0) begin start5 = 1'b1; seed5 = ~sd; num5 = 5'd1; end
      else begin start8 = 1'b1; seed8 = ~sd; num8 = 6'd1; end
      @(negedge clk);
      start5 = 1'b0;
      start8 = 1'b0;
    end
    for (int k = 0; k < 4000; k++) begin
      if ((d ? q5.size() : q8.size()) == 0) break;
      @(negedge clk);
    end
    pend = d ? q5.size() : q8.size();
    if (pend != 0) begin
      checks++;
      errors++;
      $display("FAIL d%0d_timeout: pending responses %0d, expected 0", d ? 5 : 8, pend);
      if (d != 0) q5.delete(); else q8.delete();
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ix = $urandom_range(d ? 31 : 63, 0);
      if (d != 0) rd5 = 5'(ix); else rd8 = 6'(ix);
      #1;
      chk($sformatf("d%0d_rd_bomb[%0d]", d ? 5 : 8, ix), {63'd0, d ? rdb5 : rdb8},
          {63'd0, (ix < (d ? 25 : 64)) ? last_map[d][ix] : 1'b0});
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; num8 = '0; seed8 = '0; rd8 = '0;
    start5 = 1'b0; num5 = '0; seed5 = '0; rd5 = '0;
    last_map[0] = '0;
    last_map[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_map8", map8, 64'd0);
    chk("reset_cnt8", {58'd0, cnt8}, 64'd0);
    chk("reset_flags8", {61'd0, busy8, done8, err8}, 64'd0);
    chk("reset_map5", {39'd0, map5}, 64'd0);
    chk("reset_flags5", {61'd0, busy5, done5, err5}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    req(0, 16'h1234, 10, 1'b0);
    req(0, 16'h1234, 10, 1'b1);
    req(0, 16'h0000, 20, 1'b0);
    req(0, 16'hACE1, 20, 1'b0);
    req(0, 16'($urandom), 0, 1'b0);
    req(0, 16'($urandom), 63, 1'b1);
    req(1, 16'($urandom), 24, 1'b0);
    req(1, 16'($urandom), 25 + $urandom_range(6, 0), 1'b0);
    req(1, 16'h0000, 0, 1'b0);
    rd5 = 5'd30;
    #1;
    chk("d5_rd_out_of_range", {63'd0, rdb5}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      req(0, 16'($urandom), $urandom_range(63, 0), 1'b0);
      req(1, 16'($urandom), $urandom_range(31, 0), 1'b0);
    end

    @(negedge clk);
    start8 = 1'b1; seed8 = 16'h5A5A; num8 = 6'd40;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("d8_busy_before_rst", {63'd0, busy8}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fill_map8", map8, 64'd0);
    chk("rst_fill_cnt8", {58'd0, cnt8}, 64'd0);
    chk("rst_fill_flags8", {61'd0, busy8, done8, err8}, 64'd0);
    rst = 1'b0;
    last_map[0] = '0;
    last_map[1] = '0;
    repeat (60) @(negedge clk);
    req(0, 16'h1234, 10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
